// File: rtl/qracc_seq_ctrl.sv
// qracc_seq_ctrl: sequences weight-row loads and throttled ofmap pixel requests for the accelerator
module qracc_seq_ctrl #(
  parameter int DIM_W = 8,
  parameter int CH_W = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [2:0]       trigger_i,
  input  logic             clear_i,
  input  logic [DIM_W-1:0] ofmap_h_i,
  input  logic [DIM_W-1:0] ofmap_w_i,
  input  logic [CH_W-1:0]  in_ch_i,
  output logic             busy_o,
  output logic [3:0]       state_o,
  output logic             wreq_valid_o,
  input  logic             wreq_ready_i,
  output logic [CH_W-1:0]  wreq_row_o,
  output logic             preq_valid_o,
  input  logic             preq_ready_i,
  output logic [DIM_W-1:0] preq_row_o,
  output logic [DIM_W-1:0] preq_col_o,
  input  logic             pix_done_i,
  output logic             done_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [3:0] {IDLE = 4'd0, LOADW = 4'd1, COMPUTE = 4'd2, DRAIN = 4'd3, DONE = 4'd4} state_t;
  state_t state;
  logic [CH_W-1:0] n_ch, wrow;
  logic [DIM_W-1:0] h, w, row, col;
  logic [OW-1:0] outst;
  logic w_acc, p_acc, dec;
  assign busy_o = state != IDLE;
  assign state_o = state;
  assign done_o = state == DONE;
  assign wreq_valid_o = state == LOADW;
  assign preq_valid_o = state == COMPUTE && outst < OW'(MAX_OUTSTANDING);
  assign wreq_row_o = wrow;
  assign preq_row_o = row;
  assign preq_col_o = col;
  assign w_acc = wreq_valid_o && wreq_ready_i;
  assign p_acc = preq_valid_o && preq_ready_i;
  assign dec = pix_done_i && outst != '0;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      n_ch <= '0;
      wrow <= '0;
      h <= '0;
      w <= '0;
      row <= '0;
      col <= '0;
      outst <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      n_ch <= '0;
      wrow <= '0;
      h <= '0;
      w <= '0;
      row <= '0;
      col <= '0;
      outst <= '0;
    end else begin
      case (state)
        IDLE:
          if (trigger_i == 3'd1) begin
            n_ch <= in_ch_i;
            wrow <= '0;
            state <= in_ch_i == '0 ? DONE : LOADW;
          end else if (trigger_i == 3'd2) begin
            h <= ofmap_h_i;
            w <= ofmap_w_i;
            row <= '0;
            col <= '0;
            outst <= '0;
            state <= (ofmap_h_i == '0 || ofmap_w_i == '0) ? DONE : COMPUTE;
          end
        LOADW:
          if (w_acc) begin
            wrow <= wrow + CH_W'(1);
            if (wrow == n_ch - CH_W'(1)) state <= DONE;
          end
        COMPUTE: begin
          outst <= outst + OW'(p_acc) - OW'(dec);
          if (p_acc) begin
            if (col == w - DIM_W'(1)) begin
              col <= '0;
              if (row == h - DIM_W'(1)) state <= DRAIN;
              else row <= row + DIM_W'(1);
            end else col <= col + DIM_W'(1);
          end
        end
        DRAIN: begin
          outst <= outst - OW'(dec);
          if (outst == '0) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_qracc_seq_ctrl.sv
// tb_qracc_seq_ctrl: table-driven cycle checks of qracc_seq_ctrl plus reset sequences
module tb_qracc_seq_ctrl;
  logic clk = 0, nrst = 0;
  logic [2:0] trigger_i = '0;
  logic clear_i = 0, wreq_ready_i = 0, preq_ready_i = 0, pix_done_i = 0;
  logic [7:0] ofmap_h_i = '0, ofmap_w_i = '0;
  logic [9:0] in_ch_i = '0;
  logic busy_o, wreq_valid_o, preq_valid_o, done_o;
  logic [3:0] state_o;
  logic [9:0] wreq_row_o;
  logic [7:0] preq_row_o, preq_col_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  qracc_seq_ctrl dut (
    .clk(clk), .nrst(nrst), .trigger_i(trigger_i), .clear_i(clear_i),
    .ofmap_h_i(ofmap_h_i), .ofmap_w_i(ofmap_w_i), .in_ch_i(in_ch_i),
    .busy_o(busy_o), .state_o(state_o),
    .wreq_valid_o(wreq_valid_o), .wreq_ready_i(wreq_ready_i), .wreq_row_o(wreq_row_o),
    .preq_valid_o(preq_valid_o), .preq_ready_i(preq_ready_i),
    .preq_row_o(preq_row_o), .preq_col_o(preq_col_o),
    .pix_done_i(pix_done_i), .done_o(done_o)
  );
  typedef struct {
    logic [2:0] trig;
    logic clr;
    logic [9:0] in_ch;
    logic [7:0] h, w;
    logic wr, pr, pd;
    logic [3:0] st;
    logic wv;
    logic [9:0] wrow;
    logic pv;
    logic [7:0] prow, pcol;
    logic dn;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(input int trig, clr, in_ch, h, w, wr, pr, pd, st, wv, wrow, pv, prow, pcol, dn);
    vec_t r;
    r.trig = 3'(trig);
    r.clr = 1'(clr);
    r.in_ch = 10'(in_ch);
    r.h = 8'(h);
    r.w = 8'(w);
    r.wr = 1'(wr);
    r.pr = 1'(pr);
    r.pd = 1'(pd);
    r.st = 4'(st);
    r.wv = 1'(wv);
    r.wrow = 10'(wrow);
    r.pv = 1'(pv);
    r.prow = 8'(prow);
    r.pcol = 8'(pcol);
    r.dn = 1'(dn);
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    trigger_i = '0;
    clear_i = 0;
    in_ch_i = '0;
    ofmap_h_i = '0;
    ofmap_w_i = '0;
    wreq_ready_i = 0;
    preq_ready_i = 0;
    pix_done_i = 0;
  endtask
  initial begin
    // load in_ch=3, trigger=2 mid-load must be ignored
    tbl.push_back(v(1,0,3,0,0, 1,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(v(2,0,0,0,0, 1,0,0, 1,1,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0, 1,1,2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0, 4,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 1,0,0, 0,0,0,0,0,0,0));
    // zero channels and zero dims go straight to DONE
    tbl.push_back(v(1,0,0,0,0, 1,0,0, 4,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(2,0,0,2,0, 0,1,0, 4,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(2,0,0,0,3, 0,1,0, 4,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    // compute 2x3, ready always high, pix_done two cycles after each accept
    tbl.push_back(v(2,0,0,2,3, 0,1,0, 2,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,1,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,2,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 2,0,0,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 2,0,0,1,1,1,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 2,0,0,1,1,2,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 4,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    // throttle 1x8: stray pix_done at zero outstanding, then 4 accepts fill the window
    tbl.push_back(v(2,0,0,1,8, 0,1,0, 2,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,1, 2,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,1,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,2,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,3,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,0,0,4,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,0,0,4,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1, 2,0,0,1,0,4,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,0,0,5,0));
    // abort with simultaneous trigger, restart from (0,0) with an empty window
    tbl.push_back(v(2,1,0,1,8, 0,1,0, 0,0,0,0,0,0,0));
    tbl.push_back(v(2,0,0,1,8, 0,0,0, 2,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,1,0));
    tbl.push_back(v(0,1,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    // backpressure 1x3: ready low 5 cycles while presenting (0,1)
    tbl.push_back(v(2,0,0,1,3, 0,0,0, 2,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,1,0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0,0, 0,0,0, 2,0,0,1,0,1,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 2,0,0,1,0,2,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,1, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,1, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,1, 3,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 4,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    #12;
    chk("reset state", state_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset wvalid", wreq_valid_o, 0);
    chk("reset pvalid", preq_valid_o, 0);
    chk("reset wrow", wreq_row_o, 0);
    chk("reset prow", preq_row_o, 0);
    chk("reset pcol", preq_col_o, 0);
    @(negedge clk);
    nrst = 1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      trigger_i = tbl[i].trig;
      clear_i = tbl[i].clr;
      in_ch_i = tbl[i].in_ch;
      ofmap_h_i = tbl[i].h;
      ofmap_w_i = tbl[i].w;
      wreq_ready_i = tbl[i].wr;
      preq_ready_i = tbl[i].pr;
      pix_done_i = tbl[i].pd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d state", i), state_o, tbl[i].st);
      chk($sformatf("v%0d busy", i), busy_o, tbl[i].st != 0);
      chk($sformatf("v%0d done", i), done_o, tbl[i].dn);
      chk($sformatf("v%0d wvalid", i), wreq_valid_o, tbl[i].wv);
      chk($sformatf("v%0d pvalid", i), preq_valid_o, tbl[i].pv);
      if (tbl[i].wv) chk($sformatf("v%0d wrow", i), wreq_row_o, tbl[i].wrow);
      if (tbl[i].pv) begin
        chk($sformatf("v%0d prow", i), preq_row_o, tbl[i].prow);
        chk($sformatf("v%0d pcol", i), preq_col_o, tbl[i].pcol);
      end
    end
    // asynchronous reset in the middle of a load, then no done_o afterwards
    idle_inputs();
    trigger_i = 3'd1;
    in_ch_i = 10'd5;
    @(posedge clk);
    #1;
    idle_inputs();
    wreq_ready_i = 1;
    @(posedge clk);
    #2;
    chk("mid load state", state_o, 1);
    nrst = 0;
    #1;
    chk("async rst state", state_o, 0);
    chk("async rst busy", busy_o, 0);
    chk("async rst wvalid", wreq_valid_o, 0);
    @(negedge clk);
    nrst = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post rst %0d done", k), done_o, 0);
      chk($sformatf("post rst %0d state", k), state_o, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qracc_seq_ctrl.md
QRACC_SEQ_CTRL -- requirements
Module: qracc_seq_ctrl

Interface
REQ-001 SHALL have parameter DIM_W, default 8, width of ofmap dimension fields.
REQ-002 SHALL have parameter CH_W, default 10, width of channel count fields.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, cap on accepted-but-uncompleted pixel requests.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port trigger_i  input  3  one-cycle command code (0 idle, 1 load weights, 2 compute, others ignored).
REQ-007 SHALL have port clear_i  input  1  one-cycle synchronous abort.
REQ-008 SHALL have port ofmap_h_i  input  DIM_W  output rows, sampled at compute start.
REQ-009 SHALL have port ofmap_w_i  input  DIM_W  output columns, sampled at compute start.
REQ-010 SHALL have port in_ch_i  input  CH_W  weight rows to load, sampled at load start.
REQ-011 SHALL have port busy_o  output  1  high when state is not IDLE.
REQ-012 SHALL have port state_o  output  4  current state encoding.
REQ-013 SHALL have port wreq_valid_o / wreq_ready_i / wreq_row_o  out/in/out  1/1/CH_W  weight-row load handshake and row index.
REQ-014 SHALL have port preq_valid_o / preq_ready_i  out/in  1/1  pixel compute request handshake.
REQ-015 SHALL have ports preq_row_o, preq_col_o  output  DIM_W each  pixel coordinate of current request.
REQ-016 SHALL have port pix_done_i  input  1  one-cycle pulse per completed pixel.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse at end of load or compute.

Function
REQ-018 SHALL implement states IDLE=0, LOADW=1, COMPUTE=2, DRAIN=3, DONE=4; state_o equals encoding.
REQ-019 SHALL, in IDLE, on trigger_i==1: latch in_ch_i, zero row counter, go LOADW; if in_ch_i==0 go DONE instead.
REQ-020 SHALL, in IDLE, on trigger_i==2: latch ofmap_h_i/ofmap_w_i, zero row/col, outstanding=0, go COMPUTE; if either dim is 0 go DONE instead.
REQ-021 SHALL ignore trigger_i in every state other than IDLE.
REQ-022 SHALL, in LOADW, drive wreq_valid_o=1 with wreq_row_o=row counter; on wreq_valid&&wreq_ready increment; after row in_ch-1 accepted go DONE.
REQ-023 SHALL, in COMPUTE, drive preq_valid_o=1 only when outstanding<MAX_OUTSTANDING; coordinates held stable while valid and not ready.
REQ-024 SHALL advance col on each accepted request; at col==w-1 wrap col to 0 and increment row; after (h-1,w-1) accepted go DRAIN.
REQ-025 SHALL keep outstanding counter: +1 on accept, -1 on pix_done_i, unchanged when both in same cycle.
REQ-026 SHALL ignore pix_done_i when outstanding==0 (no underflow).
REQ-027 SHALL, in DRAIN, go DONE in the cycle after outstanding reaches 0 (including if already 0 on entry).
REQ-028 SHALL assert done_o for exactly the one cycle spent in DONE, then return to IDLE.
REQ-029 SHALL, on clear_i in any state, go IDLE next cycle, zero all counters, deassert all valids, suppress done_o; clear_i wins over simultaneous trigger_i.
REQ-030 SHALL never drop an asserted valid before its ready except on clear_i or reset.
REQ-031 SHALL drive wreq_valid_o=0 outside LOADW and preq_valid_o=0 outside COMPUTE.

Reset
REQ-032 SHALL on nrst low asynchronously set state IDLE, all counters and latched dims 0, busy_o=0, state_o=0, done_o=0, all valids 0, all row/col outputs 0.
REQ-033 SHALL, if reset asserts mid-operation, discard the operation; no done_o after release.

Verification
REQ-034 SHALL cover load: in_ch=3, ready always 1, trigger=1 -> wreq_row 0,1,2 on consecutive cycles, done_o one cycle later, busy low after.
REQ-035 SHALL cover compute: h=2,w=3, ready always 1, pix_done 2 cycles after each accept -> coordinates (0,0)..(1,2) row-major, done_o only after 6th pix_done.
REQ-036 SHALL cover throttle: h=1,w=8, MAX_OUTSTANDING=4, no pix_done -> exactly 4 accepts then preq_valid_o low until a pix_done arrives.
REQ-037 SHALL cover backpressure: ready low 5 cycles at (0,1) -> valid and coordinates stable throughout, no skipped pixel.
REQ-038 SHALL cover zero dims: trigger=2 with w=0 -> DONE then IDLE, done_o one cycle, no preq_valid_o.
REQ-039 SHALL cover abort: clear_i with trigger=2 mid-COMPUTE -> IDLE next cycle, outstanding 0, no done_o; new trigger restarts from (0,0).
